mem_port_arbiter: RTL

Shares one single-port synchronous word memory between the instruction-fetch requester and the data-memory requester of the 5-stage MIPS pipeline, so both can live in a unified instruction/data RAM.

- Grants at most one access per cycle.
- Data port has priority by default; a starvation counter guarantees instruction-fetch progress.
- Read data is routed back to the port that issued the read, one cycle after the grant.
- An instruction-side flush input discards fetch returns when a taken branch redirects the PC.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - instruction/data arbiter for one single-port synchronous word memory
module mem_port_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_flush,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      RSEL_NONE = 2'd0,
      RSEL_I    = 2'd1,
      RSEL_D    = 2'd2
   } rsel_t;

   rsel_t         rsel, rsel_nxt;
   logic [CW-1:0] icnt, icnt_nxt;
   logic          i_eff, starve, i_win, d_win;

   // Data wins unless the fetch side has been denied STARVE_MAX cycles in a row.
   always_comb begin
      i_eff   = i_req & ~i_flush;
      starve  = i_eff & (icnt == CNT_MAX);
      d_win   = rst & d_req & ~starve;
      i_win   = rst & i_eff & ~d_win;
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (d_win) begin
         m_en    = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (i_win) begin
         m_en   = 1'b1;
         m_addr = i_addr;
      end
   end

   assign i_gnt = i_win;
   assign d_gnt = d_win;

   always_comb begin
      icnt_nxt = icnt;
      rsel_nxt = RSEL_NONE;
      if (i_win || !i_eff) begin
         icnt_nxt = '0;
      end else if (icnt != CNT_MAX) begin
         icnt_nxt = icnt + 1'b1;
      end
      if (i_win) begin
         rsel_nxt = RSEL_I;
      end else if (d_win && !d_we) begin
         rsel_nxt = RSEL_D;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         icnt <= '0;
         rsel <= RSEL_NONE;
      end else begin
         icnt <= icnt_nxt;
         rsel <= rsel_nxt;
      end
   end

   // A flush in the return cycle drops the fetch data that arrives then.
   assign i_rvalid = rst & (rsel == RSEL_I) & ~i_flush;
   assign d_rvalid = rst & (rsel == RSEL_D);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule
